// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline definitions: ALU/bus/writeback encodings plus hazard scoreboard types.
package hazard_fwd_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {BUS_IDLE, BUS_READ, BUS_WRITE} bus_op_e;

  typedef enum logic [1:0] {WB_NONE, WB_ALU, WB_MEM, WB_PC4} wb_sel_e;

  // Scoreboard rd field is sized for the widest supported register index.
  localparam int SB_RD_MAX = 8;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                 vld;
    logic [SB_RD_MAX-1:0] rd;
    logic                 load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    CTL_RUN, CTL_MEM_WAIT, CTL_FLUSH, CTL_LOAD_USE
  } ctl_mode_e;

endpackage

// File: rtl/hazard_sb.sv
// Destination scoreboard: entry 1 mirrors ID/EX, entry k mirrors stage k.
// Shifts one place on every pipeline advance, frozen otherwise.
module hazard_sb
  import hazard_fwd_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adv_i,
  input  sb_entry_t             ent_i,
  output sb_entry_t [DEPTH:1]   ent_o
);

  localparam logic [SB_RD_MAX-1:0] RD_MASK = SB_RD_MAX'((1 << REG_W) - 1);

  sb_entry_t [DEPTH:1] ent_q;
  sb_entry_t [DEPTH:1] ent_d;

  always_comb begin
    ent_d = ent_q;
    if (adv_i) begin
      ent_d[1]      = ent_i;
      ent_d[1].rd   = ent_i.rd & RD_MASK;
      for (int k = 2; k <= DEPTH; k++) begin
        ent_d[k] = ent_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q <= '0;
    end else begin
      ent_q <= ent_d;
    end
  end

  assign ent_o = ent_q;

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand-forwarding control for an in-order pipeline.
// Forward selects and stall/flush controls are combinational from the scoreboard.
module hazard_fwd_unit
  import hazard_fwd_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int DEPTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_vld,
  input  logic [REG_W-1:0]           id_rs1,
  input  logic [REG_W-1:0]           id_rs2,
  input  logic                       id_rs1_used,
  input  logic                       id_rs2_used,
  input  logic [REG_W-1:0]           id_rd,
  input  logic                       id_wr,
  input  logic                       id_load,
  input  logic                       mem_ready,
  input  logic                       flush_req,
  output logic                       flush_ack,
  output logic                       stall_if,
  output logic                       stall_id,
  output logic                       kill_if_id,
  output logic                       bubble_ex,
  output logic                       pipe_adv,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs1,
  output logic [$clog2(DEPTH+1)-1:0] fwd_rs2,
  output logic [XLEN-1:0]            stall_cnt
);

  localparam int FW = $clog2(DEPTH + 1);

  sb_entry_t [DEPTH:1]  ent;
  sb_entry_t            ent_new;
  logic [SB_RD_MAX-1:0] rs1_x;
  logic [SB_RD_MAX-1:0] rs2_x;
  logic [DEPTH:1]       m1;
  logic [DEPTH:1]       m2;
  logic                 load_use;
  ctl_mode_e            mode;
  logic [XLEN-1:0]      stall_cnt_q;
  logic [XLEN-1:0]      stall_cnt_d;

  assign rs1_x = SB_RD_MAX'(id_rs1);
  assign rs2_x = SB_RD_MAX'(id_rs2);

  assign ent_new.vld  = id_vld & id_wr & ~bubble_ex;
  assign ent_new.rd   = SB_RD_MAX'(id_rd);
  assign ent_new.load = id_load;

  hazard_sb #(
    .DEPTH (DEPTH),
    .REG_W (REG_W)
  ) u_sb (
    .clk   (clk),
    .rst   (rst),
    .adv_i (pipe_adv),
    .ent_i (ent_new),
    .ent_o (ent)
  );

  // x0 is hardwired, so a zero index never produces a hazard.
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      m1[k] = ent[k].vld && id_rs1_used && (rs1_x != '0) && (ent[k].rd == rs1_x);
      m2[k] = ent[k].vld && id_rs2_used && (rs2_x != '0) && (ent[k].rd == rs2_x);
    end
  end

  assign load_use = id_vld && ent[1].load && (m1[1] || m2[1]);

  // Scanning oldest to youngest lets the youngest match overwrite the choice.
  always_comb begin
    fwd_rs1 = FW'(FWD_RF);
    fwd_rs2 = FW'(FWD_RF);
    for (int k = DEPTH; k >= 1; k--) begin
      if (m1[k] && !(k == 1 && ent[1].load)) fwd_rs1 = FW'(k);
      if (m2[k] && !(k == 1 && ent[1].load)) fwd_rs2 = FW'(k);
    end
    if (rst) begin
      fwd_rs1 = FW'(FWD_RF);
      fwd_rs2 = FW'(FWD_RF);
    end
  end

  always_comb begin
    mode = CTL_RUN;
    if (rst)             mode = CTL_RUN;
    else if (!mem_ready) mode = CTL_MEM_WAIT;
    else if (flush_req)  mode = CTL_FLUSH;
    else if (load_use)   mode = CTL_LOAD_USE;
  end

  always_comb begin
    pipe_adv   = 1'b1;
    stall_if   = 1'b0;
    stall_id   = 1'b0;
    kill_if_id = 1'b0;
    bubble_ex  = 1'b0;
    flush_ack  = 1'b0;
    unique case (mode)
      CTL_MEM_WAIT: begin
        pipe_adv = 1'b0;
        stall_if = 1'b1;
        stall_id = 1'b1;
      end
      CTL_FLUSH: begin
        flush_ack  = 1'b1;
        kill_if_id = 1'b1;
        bubble_ex  = 1'b1;
      end
      CTL_LOAD_USE: begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        bubble_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_cnt_d = (stall_id && !(&stall_cnt_q)) ? stall_cnt_q + XLEN'(1) : stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit at DEPTH=3 with a DEPTH=5 instance alongside.
module tb_hazard_fwd_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       id_vld, id_rs1_used, id_rs2_used, id_wr, id_load, mem_ready, flush_req;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        flush_ack, stall_if, stall_id, kill_if_id, bubble_ex, pipe_adv;
  logic [1:0]  fwd_rs1, fwd_rs2;
  logic [31:0] stall_cnt;

  logic        flush_ack5, stall_if5, stall_id5, kill_if_id5, bubble_ex5, pipe_adv5;
  logic [2:0]  fwd_rs1_5, fwd_rs2_5;
  logic [31:0] stall_cnt5;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  hazard_fwd_unit #(.XLEN(32), .REG_W(5), .DEPTH(3)) u_dut (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .mem_ready(mem_ready), .flush_req(flush_req), .flush_ack(flush_ack),
    .stall_if(stall_if), .stall_id(stall_id), .kill_if_id(kill_if_id), .bubble_ex(bubble_ex),
    .pipe_adv(pipe_adv), .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .stall_cnt(stall_cnt)
  );

  hazard_fwd_unit #(.XLEN(32), .REG_W(5), .DEPTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .id_vld(id_vld), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_wr(id_wr),
    .id_load(id_load), .mem_ready(mem_ready), .flush_req(flush_req), .flush_ack(flush_ack5),
    .stall_if(stall_if5), .stall_id(stall_id5), .kill_if_id(kill_if_id5), .bubble_ex(bubble_ex5),
    .pipe_adv(pipe_adv5), .fwd_rs1(fwd_rs1_5), .fwd_rs2(fwd_rs2_5), .stall_cnt(stall_cnt5)
  );

  task automatic idle();
    id_vld = 0; id_rs1_used = 0; id_rs2_used = 0; id_wr = 0; id_load = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; mem_ready = 1; flush_req = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drain();
    idle();
    repeat (6) tick();
  endtask

  task automatic issue_wr(input logic [4:0] rd, input logic ld);
    idle(); id_vld = 1; id_wr = 1; id_rd = rd; id_load = ld;
  endtask

  task automatic test_reset();
    rst = 1; idle(); mem_ready = 0; flush_req = 1;
    #2;
    total++; if (pipe_adv !== 1'b1) begin bad++; $display("FAIL reset_pipe_adv: got %b want 1", pipe_adv); end
    total++; if ({stall_if, stall_id, kill_if_id, bubble_ex, flush_ack} !== 5'b0) begin bad++; $display("FAIL reset_ctl: got %b want 00000", {stall_if, stall_id, kill_if_id, bubble_ex, flush_ack}); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    total++; if ({fwd_rs1, fwd_rs2} !== 4'd0) begin bad++; $display("FAIL reset_fwd: got %0d/%0d want 0/0", fwd_rs1, fwd_rs2); end
    idle();
    #10 rst = 0;
    tick();
  endtask

  task automatic test_alu_chain();
    issue_wr(5'd5, 0); tick();
    idle(); id_vld = 1; id_rs1 = 5; id_rs1_used = 1; id_rs2 = 5; id_rs2_used = 0;
    #1;
    total++; if (fwd_rs1 !== 2'd1) begin bad++; $display("FAIL alu_fwd_e1: got %0d want 1", fwd_rs1); end
    total++; if (fwd_rs2 !== 2'd0) begin bad++; $display("FAIL alu_unused_rs2: got %0d want 0", fwd_rs2); end
    total++; if (stall_id !== 1'b0 || pipe_adv !== 1'b1) begin bad++; $display("FAIL alu_nostall: got stall_id=%b pipe_adv=%b want 0/1", stall_id, pipe_adv); end
    tick(); #1;
    total++; if (fwd_rs1 !== 2'd2) begin bad++; $display("FAIL alu_fwd_e2: got %0d want 2", fwd_rs1); end
    drain();
  endtask

  task automatic test_load_use();
    issue_wr(5'd7, 1); tick();
    idle(); id_vld = 1; id_rs2 = 7; id_rs2_used = 1;
    #1;
    total++; if ({stall_if, stall_id, bubble_ex, pipe_adv, kill_if_id} !== 5'b11110) begin bad++; $display("FAIL lu_stall: got %b want 11110", {stall_if, stall_id, bubble_ex, pipe_adv, kill_if_id}); end
    total++; if (fwd_rs2 !== 2'd0) begin bad++; $display("FAIL lu_no_e1_fwd: got %0d want 0", fwd_rs2); end
    tick(); exp_cnt = 1; #1;
    total++; if (stall_id !== 1'b0 || bubble_ex !== 1'b0) begin bad++; $display("FAIL lu_one_cycle: got stall_id=%b bubble=%b want 0/0", stall_id, bubble_ex); end
    total++; if (fwd_rs2 !== 2'd2) begin bad++; $display("FAIL lu_fwd_e2: got %0d want 2", fwd_rs2); end
    total++; if (stall_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    drain();
  endtask

  task automatic test_rd_zero();
    issue_wr(5'd0, 1); tick();
    idle(); id_vld = 1; id_rs1 = 0; id_rs1_used = 1; id_rs2 = 0; id_rs2_used = 1;
    #1;
    total++; if ({fwd_rs1, fwd_rs2} !== 4'd0) begin bad++; $display("FAIL rd0_fwd: got %0d/%0d want 0/0", fwd_rs1, fwd_rs2); end
    total++; if (stall_id !== 1'b0 || bubble_ex !== 1'b0) begin bad++; $display("FAIL rd0_nostall: got stall_id=%b bubble=%b want 0/0", stall_id, bubble_ex); end
    drain();
  endtask

  task automatic test_memwait_flush();
    issue_wr(5'd3, 1); tick();
    idle(); id_vld = 1; id_rs1 = 3; id_rs1_used = 1; mem_ready = 0; flush_req = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({flush_ack, pipe_adv, stall_if, stall_id, bubble_ex, kill_if_id} !== 6'b001100) begin bad++; $display("FAIL mw_ctl[%0d]: got %b want 001100", c, {flush_ack, pipe_adv, stall_if, stall_id, bubble_ex, kill_if_id}); end
      tick(); exp_cnt++;
    end
    total++; if (stall_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL mw_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    mem_ready = 1;
    #1;
    total++; if ({flush_ack, kill_if_id, bubble_ex, stall_if, stall_id, pipe_adv} !== 6'b111001) begin bad++; $display("FAIL flush_ctl: got %b want 111001", {flush_ack, kill_if_id, bubble_ex, stall_if, stall_id, pipe_adv}); end
    tick();
    flush_req = 0;
    #1;
    total++; if (fwd_rs1 !== 2'd2) begin bad++; $display("FAIL mw_frozen: got %0d want 2", fwd_rs1); end
    total++; if (stall_cnt !== 32'(exp_cnt)) begin bad++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    drain();
  endtask

  task automatic test_priority();
    issue_wr(5'd9, 0); tick();
    idle(); tick();
    tick();
    id_vld = 1; id_rs1 = 9; id_rs1_used = 1;
    #1;
    total++; if (fwd_rs1 !== 2'd3) begin bad++; $display("FAIL prio_e3: got %0d want 3", fwd_rs1); end
    idle(); tick(); tick();
    id_vld = 1; id_rs1 = 9; id_rs1_used = 1;
    #1;
    total++; if (fwd_rs1 !== 2'd0) begin bad++; $display("FAIL prio_gone3: got %0d want 0", fwd_rs1); end
    total++; if (fwd_rs1_5 !== 3'd5) begin bad++; $display("FAIL prio_e5: got %0d want 5", fwd_rs1_5); end
    drain();
    issue_wr(5'd9, 0); tick();
    idle(); tick();
    issue_wr(5'd9, 0); tick();
    idle(); id_vld = 1; id_rs1 = 9; id_rs1_used = 1;
    #1;
    total++; if (fwd_rs1 !== 2'd1) begin bad++; $display("FAIL prio_young: got %0d want 1", fwd_rs1); end
    total++; if (fwd_rs1_5 !== 3'd1) begin bad++; $display("FAIL prio_young5: got %0d want 1", fwd_rs1_5); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    issue_wr(5'd7, 1); tick();
    idle(); id_vld = 1; id_rs2 = 7; id_rs2_used = 1;
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL rms_pre: got %b want 1", stall_id); end
    #1 rst = 1;
    #1;
    total++; if ({stall_if, stall_id, bubble_ex, kill_if_id, flush_ack, pipe_adv} !== 6'b000001) begin bad++; $display("FAIL rms_ctl: got %b want 000001", {stall_if, stall_id, bubble_ex, kill_if_id, flush_ack, pipe_adv}); end
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rms_cnt: got %0d want 0", stall_cnt); end
    #1 rst = 0;
    #1;
    total++; if (stall_id !== 1'b0 || fwd_rs2 !== 2'd0) begin bad++; $display("FAIL rms_cleared: got stall_id=%b fwd_rs2=%0d want 0/0", stall_id, fwd_rs2); end
    tick(); #1;
    total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rms_cnt_after: got %0d want 0", stall_cnt); end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use();
    test_rd_zero();
    test_memwait_flush();
    test_priority();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_unit.md
HAZARD_FWD_UNIT -- requirements
Module: hazard_fwd_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (used only for the stall counter width).
REQ-002 SHALL have parameter REG_W, default 5, register-index width.
REQ-003 SHALL have parameter DEPTH, default 3, number of tracked downstream stages (1=EX, 2=MEM, ... DEPTH=WB); legal range 2..6.
REQ-004 SHALL have ports: clk  in  1  clock; rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports: id_vld  in  1  ID holds a valid instruction; id_rs1/id_rs2  in  REG_W  sources; id_rs1_used/id_rs2_used  in  1  source read.
REQ-006 SHALL have ports: id_rd  in  REG_W  destination; id_wr  in  1  writes rd; id_load  in  1  instruction is a load.
REQ-007 SHALL have ports: mem_ready  in  1  data memory accepts/completes this cycle; flush_req  in  1  branch redirect from EX, held until accepted.
REQ-008 SHALL have ports: flush_ack  out  1  flush accepted; stall_if  out  1  hold PC; stall_id  out  1  hold IF/ID.
REQ-009 SHALL have ports: kill_if_id  out  1  load NOP into IF/ID; bubble_ex  out  1  load NOP into ID/EX; pipe_adv  out  1  EX..WB registers advance.
REQ-010 SHALL have ports: fwd_rs1/fwd_rs2  out  $clog2(DEPTH+1)  0=register file, k=stage k result; stall_cnt  out  XLEN  stall-cycle count.

Function
REQ-011 SHALL hold a scoreboard of DEPTH entries {vld, rd, load}; entry 1 mirrors ID/EX, entry k mirrors stage k.
REQ-012 SHALL, on a cycle with pipe_adv=1, shift entry k into k+1 (entry DEPTH discarded) and load entry 1 with {id_vld & id_wr & ~bubble_ex, id_rd, id_load}.
REQ-013 SHALL hold all entries unchanged when pipe_adv=0.
REQ-014 SHALL treat rd=0 as never matching; an entry matches a source only if vld=1, rd equal, and the corresponding *_used=1.
REQ-015 SHALL select, per source, the lowest-index matching entry (youngest wins); fwd=0 when no entry matches; fwd outputs are combinational, zero latency.
REQ-016 SHALL assert load-use when id_vld=1 and entry 1 matches a used source with load=1; forwarding from entry 1 is never selected for a load.
REQ-017 SHALL drive a mem-wait state when mem_ready=0: pipe_adv=0, stall_if=1, stall_id=1, bubble_ex=0, kill_if_id=0, flush_ack=0.
REQ-018 SHALL, when mem_ready=1 and flush_req=1: flush_ack=1, kill_if_id=1, bubble_ex=1, stall_if=0, stall_id=0, pipe_adv=1 (flush beats load-use).
REQ-019 SHALL, when mem_ready=1, flush_req=0 and load-use: stall_if=1, stall_id=1, bubble_ex=1, pipe_adv=1, for exactly one cycle per load.
REQ-020 SHALL otherwise drive pipe_adv=1 and all stall/kill/bubble/ack outputs 0.
REQ-021 SHALL increment stall_cnt by 1 on each cycle with stall_id=1, saturating at all-ones.
REQ-022 SHALL keep flush_req pending across mem-wait; acknowledgement occurs on the first cycle with mem_ready=1.

Reset
REQ-023 SHALL on rst clear all scoreboard vld bits, rd and load fields to 0, and stall_cnt to 0, immediately and independently of clk.
REQ-024 SHALL, while rst=1, output fwd_rs1=fwd_rs2=0, pipe_adv=1 and all stall/kill/bubble/ack outputs 0.
REQ-025 SHALL discard an in-progress load-use stall or mem-wait on reset; no state survives.

Structure
REQ-026 SHALL place the scoreboard entry struct and fwd-select constants (FWD_RF=0) in the shared pipeline package with the existing ALU/BUS/WB defines.
REQ-027 SHALL implement the scoreboard as one sub-module, hazard_sb, parametrised by DEPTH and REG_W; match/priority/control logic stays in hazard_fwd_unit.

Verification
REQ-028 SHALL verify ALU chain: add x5 into entry 1, ID uses rs1=5 -> fwd_rs1=1, no stall; next cycle -> fwd_rs1=2.
REQ-029 SHALL verify load-use: load x7 in entry 1, ID rs2=7 -> one cycle stall_id=1, bubble_ex=1; then fwd_rs2=2, stall_cnt=1.
REQ-030 SHALL verify rd=0: entry 1 {vld=1, rd=0}, ID rs1=0 -> fwd_rs1=0, no stall.
REQ-031 SHALL verify mem-wait plus flush: mem_ready=0 for 3 cycles with flush_req=1 -> flush_ack=0, entries frozen, stall_cnt=3; then mem_ready=1 -> flush_ack=1, kill_if_id=1, bubble_ex=1.
REQ-032 SHALL verify priority: x9 in entries 1 and 3 -> fwd_rs1=1; DEPTH=5 build -> entry 5 match gives fwd=5.
REQ-033 SHALL verify reset mid-stall: rst pulse during load-use -> all entries invalid, stall_cnt=0, outputs at REQ-024 values.
